shift_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the ALU shift datapath. It latches an operand, a shift amount and an opcode on a start handshake. It then applies one log-shifter stage per clock (by 1, 2, 4, ... in order), with each stage enabled by the matching amount bit. It returns the result with a one-cycle done strobe and lets the ALU top time-share a single shift stage instead of a full combinational barrel.

---
 rtl/shift_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle log-shifter sequencer: one shift stage (by 1, 2, 4, ...) per clock.
// Optional SHIFT_SEQ_EARLY_EXIT_EN: finish once no higher amount bits remain set.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int unsigned K_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(AMT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [K_W-1:0]   k_q;
    logic [WIDTH-1:0] work_q;
    logic [AMT_W-1:0] amt_q;
    logic [1:0]       op_q;
    logic             sign_q;

    logic             accept_c;
    logic             direct_c;
    logic             finish_c;
    logic             stage_last_c;
    logic [AMT_W-1:0] dist_c;
    logic [WIDTH-1:0] stage_c;

    // Single log-shifter stage: distance 2^k, enabled by amt bit k
    always_comb begin
        dist_c  = AMT_W'(1) << k_q;
        stage_c = work_q;
        if (amt_q[k_q]) begin
            case (op_q)
                2'b00:   stage_c = work_q << dist_c;
                2'b01:   stage_c = work_q >> dist_c;
                2'b10:   stage_c = WIDTH'({{WIDTH{sign_q}}, work_q} >> dist_c);
                default: stage_c = WIDTH'({work_q, work_q} >> dist_c);
            endcase
        end
    end

    always_comb begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        stage_last_c = (k_q == LAST_K) || (((amt_q >> k_q) >> 1) == '0);
`else
        stage_last_c = (k_q == LAST_K);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; IDLE and DONE both accept a new request
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        direct_c = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_d  = ST_SHIFT;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                    if (amt == '0) begin
                        direct_c = 1'b1;
                        state_d  = ST_DONE;
                    end
`endif
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (stage_last_c) begin
                    finish_c = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            work_q <= '0;
            amt_q  <= '0;
            op_q   <= '0;
            sign_q <= 1'b0;
            res    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_d == ST_SHIFT);
            done <= (state_d == ST_DONE);
            if (accept_c) begin
                work_q <= a;
                amt_q  <= amt;
                op_q   <= op;
                sign_q <= a[WIDTH-1];
                k_q    <= '0;
                if (direct_c) begin
                    res <= a;
                end
            end else if (state_q == ST_SHIFT) begin
                work_q <= stage_c;
                if (finish_c) begin
                    res <= stage_c;
                end else begin
                    k_q <= k_q + K_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl (WIDTH=8, AMT_W=3); honours SHIFT_SEQ_EARLY_EXIT_EN.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00;
    logic [2:0] amt = 3'd0;
    logic       busy;
    logic       done;
    logic [7:0] res;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] res;
        int         lat;
    } exp_t;
    exp_t sb[$];

    shift_seq_ctrl #(.WIDTH(8), .AMT_W(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .a    (a),
        .amt  (amt),
        .busy (busy),
        .done (done),
        .res  (res)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_res(input logic [1:0] o, input logic [7:0] x, input logic [2:0] s);
        logic [15:0] rr;
        case (o)
            2'b00:   return x << s;
            2'b01:   return x >> s;
            2'b10:   return 8'($signed(x) >>> s);
            default: begin
                rr = {x, x} >> s;
                return rr[7:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] s);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        if (s[2]) return 3;
        if (s[1]) return 2;
        if (s[0]) return 1;
        return 0;
`else
        return (s == 3'd7) ? 3 : 3;
`endif
    endfunction

    // Drive one request across the next edge; called #1 after an edge
    task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [2:0] s);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        amt   = s;
        e.res = model_res(o, x, s);
        e.lat = model_lat(s);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~x;
        amt   = ~s;
        op    = ~o;
    endtask

    // Wait (bounded) for done; reports edges after the accept edge and busy cycles
    task automatic collect(input int lat0, input int busy0, output logic got,
                           output logic [7:0] r, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = busy0;
        got  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        r = res;
    endtask

    task automatic test_reset;
        int saw;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (res !== 8'h00) begin n_fail++; $display("FAIL reset_res: got %h expected 00", res); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(2'b10, 8'hB4, 3'd3);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midop_done: got %b expected 0", done); end
        n_tests++; if (res !== 8'h00) begin n_fail++; $display("FAIL midop_res: got %h expected 00", res); end
        #2;
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) saw++;
        end
        n_tests++; if (saw !== 0) begin n_fail++; $display("FAIL midop_no_done: got %0d active cycles expected 0", saw); end
    endtask

    task automatic test_directed;
        logic [1:0] ops [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
        logic [7:0] as  [4] = '{8'hB4, 8'hB4, 8'h81, 8'hB4};
        logic [2:0] ams [4] = '{3'd3, 3'd5, 3'd1, 3'd3};
        logic [7:0] want[4] = '{8'hF6, 8'h05, 8'h02, 8'h96};
        logic got; logic [7:0] r; int lat; int bc; exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], ams[i]);
            collect(0, 0, got, r, lat, bc);
            e = sb.pop_front();
            n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL dir%0d_timeout: got no done expected done", i); end
            n_tests++; if (r !== want[i] || r !== e.res) begin n_fail++; $display("FAIL dir%0d_res: got %h expected %h", i, r, want[i]); end
            n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL dir%0d_lat: got %0d expected %0d", i, lat, e.lat); end
            n_tests++; if (bc !== e.lat) begin n_fail++; $display("FAIL dir%0d_busy: got %0d expected %0d", i, bc, e.lat); end
            @(posedge clk);
            #1;
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_sign_edge;
        logic [1:0] ops [6] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] as  [6] = '{8'h80, 8'h7F, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        logic [2:0] ams [6] = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
        logic [7:0] want[6] = '{8'hFF, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        logic got; logic [7:0] r; int lat; int bc; exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], ams[i]);
            collect(0, 0, got, r, lat, bc);
            e = sb.pop_front();
            n_tests++; if (got !== 1'b1 || r !== want[i]) begin n_fail++; $display("FAIL edge%0d_res: got %h (done %b) expected %h", i, r, got, want[i]); end
            n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL edge%0d_lat: got %0d expected %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_ignore_busy;
        logic got; logic [7:0] r; int lat; int bc; int extra; exp_t e;
        issue(2'b00, 8'h0F, 3'd6);
        @(posedge clk);
        #1;
        start = 1'b1; a = 8'hFF; op = 2'b11; amt = 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        collect(2, 2, got, r, lat, bc);
        e = sb.pop_front();
        n_tests++; if (got !== 1'b1 || r !== 8'hC0 || r !== e.res) begin n_fail++; $display("FAIL ignore_res: got %h expected %h", r, 8'hC0); end
        n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL ignore_lat: got %0d expected %0d", lat, e.lat); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_queued: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_back_to_back;
        logic got; logic [7:0] r; int lat; int bc; exp_t e;
        issue(2'b01, 8'hB4, 3'd5);
        collect(0, 0, got, r, lat, bc);
        e = sb.pop_front();
        n_tests++; if (got !== 1'b1 || r !== e.res) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", r, e.res); end
        issue(2'b00, 8'h01, 3'd7);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble: got busy %b expected 1", busy); end
        collect(0, 0, got, r, lat, bc);
        e = sb.pop_front();
        n_tests++; if (got !== 1'b1 || r !== 8'h80) begin n_fail++; $display("FAIL b2b_res: got %h expected 80", r); end
        n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_lat: got %0d expected %0d", lat, e.lat); end
    endtask

    task automatic test_early_exit;
        logic [2:0] ams [3] = '{3'd1, 3'd4, 3'd0};
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        int want_lat[3] = '{1, 3, 0};
`else
        int want_lat[3] = '{3, 3, 3};
`endif
        logic got; logic [7:0] r; int lat; int bc; exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(2'b01, 8'hC3, ams[i]);
            collect(0, 0, got, r, lat, bc);
            e = sb.pop_front();
            n_tests++; if (got !== 1'b1 || r !== e.res) begin n_fail++; $display("FAIL early%0d_res: got %h expected %h", i, r, e.res); end
            n_tests++; if (lat !== want_lat[i]) begin n_fail++; $display("FAIL early%0d_lat: got %0d expected %0d", i, lat, want_lat[i]); end
            n_tests++; if (bc !== want_lat[i]) begin n_fail++; $display("FAIL early%0d_busy: got %0d expected %0d", i, bc, want_lat[i]); end
        end
    endtask

    task automatic test_sweep;
        logic got; logic [7:0] r; int lat; int bc; exp_t e;
        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 8; s++) begin
                for (int x = 0; x < 256; x++) begin
                    issue(2'(o), 8'(x), 3'(s));
                    collect(0, 0, got, r, lat, bc);
                    e = sb.pop_front();
                    n_tests++;
                    if (got !== 1'b1 || r !== e.res || lat !== e.lat) begin
                        n_fail++;
                        $display("FAIL sweep op%0d a=%h amt=%0d: got %h lat %0d expected %h lat %0d",
                                 o, x[7:0], s, r, lat, e.res, e.lat);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sign_edge();
        test_ignore_busy();
        test_back_to_back();
        test_early_exit();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
